// File: rtl/axis_width_downsizer_pkg.sv
// Shared helpers for the AXI-Stream width downsizer: sizing functions and the
// saturating counter step used for the dropped-beat statistic.
package axis_width_downsizer_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic int keepWidth(input int dataWidth);
        return dataWidth / 8;
    endfunction

    function automatic int laneIdxWidth(input int ratio);
        return (clog2(ratio) < 1) ? 1 : clog2(ratio);
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/axis_width_downsizer_lane_priority_encoder.sv
// Combinational lowest-set-bit encoder over the lane mask, plus any-set and
// exactly-one-set flags used for last/ready generation.
module lane_priority_encoder #(
    parameter int RATIO = 2,
    parameter int IDX_W = 1
) (
    input  logic [RATIO-1:0] mask,
    output logic [IDX_W-1:0] laneIdx,
    output logic             anySet,
    output logic             onlyOne
);

    always_comb begin
        laneIdx = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (mask[i]) begin
                laneIdx = IDX_W'(i);
            end
        end
    end

    assign anySet  = |mask;
    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign onlyOne = anySet && ((mask & (mask - RATIO'(1))) == '0);

endmodule

// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: holds one wide input beat and emits its lanes
// lowest first, optionally skipping lanes whose keep slice is empty.
module axis_width_downsizer
    import axis_width_downsizer_pkg::*;
#(
    parameter int M_DATA_WIDTH    = 32,
    parameter int RATIO           = 2,
    parameter int USER_WIDTH      = 8,
    parameter int DROP_NULL_LANES = 1
) (
    input  logic                                    clk,
    input  logic                                    resetN,
    input  logic [RATIO*M_DATA_WIDTH-1:0]           sAxisTdata,
    input  logic [RATIO*keepWidth(M_DATA_WIDTH)-1:0] sAxisTkeep,
    input  logic [USER_WIDTH-1:0]                   sAxisTuser,
    input  logic                                    sAxisTlast,
    input  logic                                    sAxisTvalid,
    output logic                                    sAxisTready,
    output logic [M_DATA_WIDTH-1:0]                 mAxisTdata,
    output logic [keepWidth(M_DATA_WIDTH)-1:0]      mAxisTkeep,
    output logic [USER_WIDTH-1:0]                   mAxisTuser,
    output logic                                    mAxisTlast,
    output logic                                    mAxisTvalid,
    input  logic                                    mAxisTready,
    output logic [15:0]                             nullBeatCount
);

    localparam int KEEP_W     = keepWidth(M_DATA_WIDTH);
    localparam int S_DATA_W   = RATIO * M_DATA_WIDTH;
    localparam int S_KEEP_W   = RATIO * KEEP_W;
    localparam int LANE_IDX_W = laneIdxWidth(RATIO);

    logic [S_DATA_W-1:0]   dataQ;
    logic [S_KEEP_W-1:0]   keepQ;
    logic [USER_WIDTH-1:0] userQ;
    logic                  lastQ;
    logic [RATIO-1:0]      laneMask;
    logic                  validQ;

    logic [RATIO-1:0]      inLaneBits;
    logic [RATIO-1:0]      loadMask;
    logic [RATIO-1:0]      maskNext;
    logic [LANE_IDX_W-1:0] laneIdx;
    logic                  anySet;
    logic                  onlyOne;
    logic                  sFire;
    logic                  mFire;
    logic                  nullDrop;

    lane_priority_encoder #(
        .RATIO (RATIO),
        .IDX_W (LANE_IDX_W)
    ) uLaneEnc (
        .mask    (laneMask),
        .laneIdx (laneIdx),
        .anySet  (anySet),
        .onlyOne (onlyOne)
    );

    assign sAxisTready = !anySet || (mAxisTready && onlyOne);
    assign sFire       = sAxisTvalid && sAxisTready;
    assign mFire       = anySet && mAxisTready;

    always_comb begin
        inLaneBits = '0;
        for (int i = 0; i < RATIO; i++) begin
            inLaneBits[i] = (DROP_NULL_LANES == 0) ? 1'b1 : |sAxisTkeep[i*KEEP_W +: KEEP_W];
        end
    end

    // An all-null beat that closes a frame still goes out once on lane 0 so
    // downstream sees the TLAST.
    always_comb begin
        loadMask = inLaneBits;
        if ((inLaneBits == '0) && sAxisTlast) begin
            loadMask = RATIO'(1);
        end
    end

    assign nullDrop = sFire && (inLaneBits == '0) && !sAxisTlast;

    always_comb begin
        maskNext = laneMask;
        if (mFire) begin
            maskNext = laneMask & ~(RATIO'(1) << laneIdx);
        end
        if (sFire) begin
            maskNext = loadMask;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dataQ         <= '0;
            keepQ         <= '0;
            userQ         <= '0;
            lastQ         <= 1'b0;
            laneMask      <= '0;
            validQ        <= 1'b0;
            nullBeatCount <= '0;
        end else begin
            laneMask <= maskNext;
            validQ   <= |maskNext;
            if (sFire) begin
                dataQ <= sAxisTdata;
                keepQ <= sAxisTkeep;
                userQ <= sAxisTuser;
                lastQ <= sAxisTlast;
            end
            if (nullDrop) begin
                nullBeatCount <= satInc16(nullBeatCount);
            end
        end
    end

    always_comb begin
        mAxisTdata = '0;
        mAxisTkeep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (laneIdx == LANE_IDX_W'(i)) begin
                mAxisTdata = dataQ[i*M_DATA_WIDTH +: M_DATA_WIDTH];
                mAxisTkeep = keepQ[i*KEEP_W +: KEEP_W];
            end
        end
    end

    assign mAxisTvalid = validQ;
    assign mAxisTuser  = userQ;
    assign mAxisTlast  = lastQ && onlyOne;

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Self-checking bench: queue-based reference model of lane splitting plus
// directed literal checks for latency, framing, null beats and reset.
module tb_axis_width_downsizer;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [63:0] sData = '0;
    logic [7:0]  sKeep = '0;
    logic [7:0]  sUser = '0;
    logic        sLast = 1'b0;
    logic        sValid = 1'b0;
    logic        sReady;
    logic [31:0] mData;
    logic [3:0]  mKeep;
    logic [7:0]  mUser;
    logic        mLast;
    logic        mValid;
    logic        mReady = 1'b0;
    logic [15:0] nullCnt;

    logic [63:0] s1Data = '0;
    logic [7:0]  s1Keep = '0;
    logic [7:0]  s1User = '0;
    logic        s1Last = 1'b0;
    logic        s1Valid = 1'b0;
    logic        s1Ready;
    logic [31:0] m1Data;
    logic [3:0]  m1Keep;
    logic [7:0]  m1User;
    logic        m1Last;
    logic        m1Valid;
    logic        m1Ready = 1'b1;
    logic [15:0] nullCnt1;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    bit randReady = 1'b0;
    beat_t expQ[$];
    int outFires[$];
    logic [15:0] expNull = '0;
    bit stallPend = 1'b0;
    beat_t stallBeat;

    always #5 clk = ~clk;

    axis_width_downsizer #(
        .M_DATA_WIDTH(32), .RATIO(2), .USER_WIDTH(8), .DROP_NULL_LANES(1)
    ) dut (
        .clk(clk), .resetN(resetN),
        .sAxisTdata(sData), .sAxisTkeep(sKeep), .sAxisTuser(sUser),
        .sAxisTlast(sLast), .sAxisTvalid(sValid), .sAxisTready(sReady),
        .mAxisTdata(mData), .mAxisTkeep(mKeep), .mAxisTuser(mUser),
        .mAxisTlast(mLast), .mAxisTvalid(mValid), .mAxisTready(mReady),
        .nullBeatCount(nullCnt)
    );

    axis_width_downsizer #(
        .M_DATA_WIDTH(32), .RATIO(2), .USER_WIDTH(8), .DROP_NULL_LANES(0)
    ) dutKeepAll (
        .clk(clk), .resetN(resetN),
        .sAxisTdata(s1Data), .sAxisTkeep(s1Keep), .sAxisTuser(s1User),
        .sAxisTlast(s1Last), .sAxisTvalid(s1Valid), .sAxisTready(s1Ready),
        .mAxisTdata(m1Data), .mAxisTkeep(m1Keep), .mAxisTuser(m1User),
        .mAxisTlast(m1Last), .mAxisTvalid(m1Valid), .mAxisTready(m1Ready),
        .nullBeatCount(nullCnt1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: non-empty lanes go out lowest first, last only on the final
    // one; an all-empty beat is either counted or sent once as a keep=0 last.
    task automatic modelInput(input logic [63:0] d, input logic [7:0] k,
                              input logic [7:0] u, input logic l);
        int lastLane;
        int n;
        beat_t b;
        lastLane = -1;
        n = 0;
        for (int i = 0; i < 2; i++) if (k[i*4 +: 4] != 4'h0) lastLane = i;
        for (int i = 0; i < 2; i++) begin
            if (k[i*4 +: 4] != 4'h0) begin
                b.d = d[i*32 +: 32];
                b.k = k[i*4 +: 4];
                b.u = u;
                b.l = l && (i == lastLane);
                expQ.push_back(b);
                n++;
            end
        end
        if (n == 0) begin
            if (l) begin
                b.d = d[31:0];
                b.k = 4'h0;
                b.u = u;
                b.l = 1'b1;
                expQ.push_back(b);
            end else if (expNull != 16'hFFFF) begin
                expNull = expNull + 16'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        cycle++;
        if (!resetN) begin
            expQ.delete();
            expNull = '0;
            stallPend = 1'b0;
        end else begin
            chk("null_count", {48'h0, nullCnt}, {48'h0, expNull});
            if (stallPend) begin
                chk("stall_valid", {63'h0, mValid}, 64'h1);
                chk("stall_data", {31'h0, mData, mKeep, mLast}, {31'h0, stallBeat.d, stallBeat.k, stallBeat.l});
            end
            stallPend = 1'b0;
            if (mValid) begin
                if (mReady) begin
                    outFires.push_back(cycle);
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got beat %h with nothing expected", mData);
                    end else begin
                        e = expQ.pop_front();
                        chk("sb_data", {32'h0, mData}, {32'h0, e.d});
                        chk("sb_keep_user_last", {51'h0, mKeep, mUser, mLast}, {51'h0, e.k, e.u, e.l});
                    end
                end else begin
                    stallPend = 1'b1;
                    stallBeat.d = mData;
                    stallBeat.k = mKeep;
                    stallBeat.u = mUser;
                    stallBeat.l = mLast;
                end
            end
            if (sValid && sReady) modelInput(sData, sKeep, sUser, sLast);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) mReady = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic sendBeat(input logic [63:0] d, input logic [7:0] k,
                            input logic [7:0] u, input logic l, output int waits);
        sData = d;
        sKeep = k;
        sUser = u;
        sLast = l;
        sValid = 1'b1;
        waits = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (sReady) begin
                @(posedge clk);
                #1;
                sValid = 1'b0;
                return;
            end
            waits++;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got no sAxisTready want handshake");
        sValid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if (!mValid && expQ.size() == 0) return;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d beats pending want 0", expQ.size());
    endtask

    initial begin
        int w;
        int waits[4];
        logic [63:0] t3Data[4];
        logic [7:0] rk;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'h0, mValid}, 64'h0);
        chk("rst_fields", {19'h0, mData, mKeep, mUser, mLast}, 64'h0);
        chk("rst_count", {48'h0, nullCnt}, 64'h0);
        #2 resetN = 1'b1;
        #1 chk("rst_sready", {63'h0, sReady}, 64'h1);

        // Test 1: full beat, two lanes, first valid one cycle after handshake
        @(posedge clk);
        #1;
        mReady = 1'b1;
        sendBeat(64'hBBBBBBBB_AAAAAAAA, 8'hFF, 8'h5A, 1'b1, w);
        chk("t1_valid0", {63'h0, mValid}, 64'h1);
        chk("t1_lane0", {19'h0, mData, mKeep, mUser, mLast}, {19'h0, 32'hAAAAAAAA, 4'hF, 8'h5A, 1'b0});
        @(posedge clk);
        #1;
        chk("t1_lane1", {19'h0, mData, mKeep, mUser, mLast}, {19'h0, 32'hBBBBBBBB, 4'hF, 8'h5A, 1'b1});
        @(posedge clk);
        #1;
        chk("t1_idle", {63'h0, mValid}, 64'h0);

        // Test 2: upper lane empty; dropped here, kept as keep=0 on the other instance
        sendBeat(64'hBBBBBBBB_AAAAAAAA, 8'h0F, 8'h11, 1'b1, w);
        chk("t2_single", {27'h0, mData, mKeep, mLast}, {27'h0, 32'hAAAAAAAA, 4'hF, 1'b1});
        @(posedge clk);
        #1;
        chk("t2_idle", {63'h0, mValid}, 64'h0);
        s1Data = 64'hBBBBBBBB_AAAAAAAA;
        s1Keep = 8'h0F;
        s1User = 8'h22;
        s1Last = 1'b1;
        s1Valid = 1'b1;
        chk("t2k_sready", {63'h0, s1Ready}, 64'h1);
        @(posedge clk);
        #1;
        s1Valid = 1'b0;
        chk("t2k_lane0", {27'h0, m1Valid, m1Data, m1Keep, m1Last}, {27'h0, 1'b1, 32'hAAAAAAAA, 4'hF, 1'b0});
        @(posedge clk);
        #1;
        chk("t2k_lane1", {19'h0, m1Data, m1Keep, m1User, m1Last}, {19'h0, 32'hBBBBBBBB, 4'h0, 8'h22, 1'b1});
        @(posedge clk);
        #1;
        chk("t2k_idle", {47'h0, m1Valid, nullCnt1}, 64'h0);

        // Test 3: back-to-back beats, no bubbles
        for (int i = 0; i < 4; i++) t3Data[i] = {32'h1000_0000 * (2 * i + 2), 32'h1000_0000 * (2 * i + 1)} | 64'h0000_00AB_0000_00CD;
        outFires.delete();
        for (int i = 0; i < 4; i++) sendBeat(t3Data[i], 8'hFF, 8'(i), i == 3, waits[i]);
        drain();
        chk("t3_waits", {32'h0, 8'(waits[0]), 8'(waits[1]), 8'(waits[2]), 8'(waits[3])}, 64'h00_01_01_01);
        chk("t3_fires", 64'(outFires.size()), 64'd8);
        if (outFires.size() == 8) chk("t3_span", 64'(outFires[7] - outFires[0]), 64'd7);

        // Test 5: null beats and counter saturation
        sendBeat(64'h0123_4567_89AB_CDEF, 8'h00, 8'h33, 1'b0, w);
        chk("t5_none", {47'h0, mValid, nullCnt}, {47'h0, 1'b0, 16'd1});
        sendBeat(64'h0123_4567_89AB_CDEF, 8'h00, 8'h44, 1'b1, w);
        chk("t5_lastnull", {11'h0, mValid, mData, mKeep, mLast, nullCnt}, {11'h0, 1'b1, 32'h89ABCDEF, 4'h0, 1'b1, 16'd1});
        for (int i = 0; i < 70000; i++) sendBeat(64'(i), 8'h00, 8'h00, 1'b0, w);
        drain();
        chk("t5_sat", {48'h0, nullCnt}, 64'hFFFF);

        // Test 4: same beats as test 3 under random backpressure, then random traffic
        randReady = 1'b1;
        for (int i = 0; i < 4; i++) sendBeat(t3Data[i], 8'hFF, 8'(i), i == 3, w);
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                case ($urandom_range(0, 3))
                    0: rk[i*4 +: 4] = 4'h0;
                    1: rk[i*4 +: 4] = 4'hF;
                    default: rk[i*4 +: 4] = 4'($urandom_range(0, 15));
                endcase
            end
            sendBeat({$urandom, $urandom}, rk, 8'($urandom), 1'($urandom_range(0, 1)), w);
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end
        randReady = 1'b0;
        #0 mReady = 1'b1;
        drain();
        chk("t4_empty", 64'(expQ.size()), 64'd0);

        // Test 6: reset between lanes
        @(posedge clk);
        #1;
        mReady = 1'b0;
        sendBeat(64'h2222_2222_1111_1111, 8'hFF, 8'h66, 1'b1, w);
        mReady = 1'b1;
        @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        chk("t6_async_valid", {63'h0, mValid}, 64'h0);
        chk("t6_async_count", {48'h0, nullCnt}, 64'h0);
        @(posedge clk);
        #2 resetN = 1'b1;
        #1;
        chk("t6_sready", {62'h0, sReady, mValid}, 64'h2);
        @(posedge clk);
        #1;
        sendBeat(64'h4444_4444_3333_3333, 8'hFF, 8'h77, 1'b1, w);
        chk("t6_lane0", {27'h0, mValid, mData, mKeep, mLast}, {27'h0, 1'b1, 32'h33333333, 4'hF, 1'b0});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_width_downsizer.md
Name: axis_width_downsizer

Overview:
Single-clock AXI-Stream width downsizer, the parametrised successor of the fixed 64-to-32 downconverter used in the Aurora link path. Splits each RATIO*M_DATA_WIDTH input beat into up to RATIO output beats, with full tready backpressure on both sides. Optionally drops all-null lanes. Carries TUSER per beat (CRC flags) and preserves TLAST framing. Sits after any clock-domain crossing, in the user-clock domain, between MGT-side buses and the 32-bit user stream.

Parameters:
M_DATA_WIDTH, 32, output data width in bits; multiple of 8
RATIO, 2, input/output width ratio; >=1
USER_WIDTH, 8, TUSER width; copied unchanged to every output beat
DROP_NULL_LANES, 1, 1 = skip lanes whose keep slice is all zero; 0 = emit every lane

Ports:
clk  in  1  single clock
resetN  in  1  asynchronous active-low reset
sAxisTdata  in  RATIO*M_DATA_WIDTH  input data; lane 0 = LSBs
sAxisTkeep  in  RATIO*M_DATA_WIDTH/8  input byte enables
sAxisTuser  in  USER_WIDTH  input sideband
sAxisTlast  in  1  end of frame
sAxisTvalid  in  1  input valid
sAxisTready  out  1  input ready
mAxisTdata  out  M_DATA_WIDTH  output data
mAxisTkeep  out  M_DATA_WIDTH/8  output byte enables
mAxisTuser  out  USER_WIDTH  output sideband
mAxisTlast  out  1  end of frame
mAxisTvalid  out  1  output valid
mAxisTready  in  1  output ready
nullBeatCount  out  16  saturating count of input beats dropped entirely

Behaviour:
- Reset (async assert, sync release): mAxisTvalid=0, mAxisTdata/keep/user/last=0, holding register empty, lane mask=0, nullBeatCount=0. sAxisTready=1 once reset is released.
- Holding register captures data/keep/user/last on input handshake (sAxisTvalid & sAxisTready). It also captures laneMask[RATIO-1:0], where bit i = |keep slice i. With DROP_NULL_LANES=0, laneMask is all ones.
- Output lane = lowest set bit of laneMask. This is a combinational priority encoder on the registered mask.
- mAxisTvalid is registered and is high while laneMask != 0. mAxisTdata/keep come from the selected lane. mAxisTuser = captured user.
- mAxisTlast = captured last AND the selected lane is the only set bit.
- On output handshake, the selected lane bit is cleared. Output fields remain stable while mAxisTvalid & !mAxisTready (AXI rule).
- sAxisTready = (laneMask==0) | (mAxisTready & onlyOneBitSet). This is a combinational path from mAxisTready and is permitted. It gives back-to-back input with zero bubble cycles.
- Latency: input handshake at cycle N gives first mAxisTvalid at N+1. Throughput is 1 output beat per cycle while mAxisTready=1.
- All-null input beat (keep==0, DROP_NULL_LANES=1):
  - last=0: the beat is consumed, nothing is emitted, nullBeatCount increments. The counter saturates at 0xFFFF.
  - last=1: exactly one output beat is emitted with keep=0, data=lane 0, last=1, preserving framing. The counter does not increment.
- RATIO=1: behaves as a registered one-entry pipeline stage. The null-lane rule still applies.
- Simultaneous load and drain in one cycle: the final lane transfers out and the new beat loads, so the next cycle presents the new beat's first lane.
- Reset mid-frame: the partial beat and frame are discarded. No TLAST is emitted for it. Downstream is responsible for frame recovery.
- No TLAST/TKEEP checking is performed. Keep is passed through as given; sparse keep inside a lane is not compacted.

Decomposition:
- Shared package holds:
  - the clog2 function;
  - localparams KEEP_W = M_DATA_WIDTH/8, S_DATA_W = RATIO*M_DATA_WIDTH and LANE_IDX_W = max(1, clog2(RATIO));
  - the saturating-increment helper.
- One sub-module, lane_priority_encoder: purely combinational. It takes the RATIO-bit mask and returns the lowest-set index, an any-set flag and a one-hot-only flag.
- The rest stays in the top module. Expected size is ~180 RTL lines.

Test Plan:
1. RATIO=2, input data 0xBBBBBBBB_AAAAAAAA, keep 0xFF, last 1, mAxisTready=1 -> out 0xAAAAAAAA keep 0xF last 0, then 0xBBBBBBBB keep 0xF last 1, in consecutive cycles starting one cycle after the handshake.
2. keep 0x0F, last 1 -> single beat 0xAAAAAAAA keep 0xF last 1. With DROP_NULL_LANES=0 -> two beats, the second with keep 0x0 and last 1.
3. 4 back-to-back input beats, sAxisTvalid held high, mAxisTready=1 -> 8 output beats in 8 consecutive cycles; sAxisTready pattern 1,0,1,0,...; no bubbles.
4. Same stimulus with mAxisTready following a pseudo-random pattern (~50% high) -> output sequence identical to test 3; data, keep and last stable whenever valid&!ready; no loss or duplication (scoreboard).
5. keep=0 last=0 -> no output, nullBeatCount=1. Then keep=0 last=1 -> one beat keep 0x0 last 1, count stays 1. Then force 70000 null beats -> count holds 0xFFFF.
6. Assert resetN=0 between the first and second lanes of a beat -> mAxisTvalid=0 asynchronously, count=0. After release, sAxisTready=1 and the next beat emits from lane 0.
